// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package fifo_pkg;

   // Coarse fill-level encoding reported on the level output.
   localparam logic [1:0] LVL_Q0 = 2'd0;
   localparam logic [1:0] LVL_Q1 = 2'd1;
   localparam logic [1:0] LVL_Q2 = 2'd2;
   localparam logic [1:0] LVL_Q3 = 2'd3;

   function automatic int unsigned depth(input int unsigned a);
      return 32'd1 << a;
   endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Dual-port storage: one synchronous write port, one synchronous read port
// with an enable-gated, clearable output register.
module fifo_sc_ram
   import fifo_pkg::*;
#(
   parameter int unsigned dw = 8,
   parameter int unsigned aw = 8
) (
   input  logic          clk,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [aw-1:0] waddr_i,
   input  logic [dw-1:0] wdata_i,
   input  logic          re_i,
   input  logic [aw-1:0] raddr_i,
   output logic [dw-1:0] rdata_o
);

   localparam int unsigned DEPTH = depth(aw);

   logic [dw-1:0] mem [DEPTH];

   // Storage is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/generic_fifo_sc.sv
// Single-clock FIFO with registered read data, exact and threshold flags,
// registered flag copies and a 2-bit coarse fill level.
module generic_fifo_sc
   import fifo_pkg::*;
#(
   parameter int unsigned dw = 8,
   parameter int unsigned aw = 8,
   parameter int unsigned n  = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [dw-1:0] din,
   input  logic          we,
   input  logic          re,
   output logic [dw-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic          full_r,
   output logic          empty_r,
   output logic          full_n,
   output logic          empty_n,
   output logic          full_n_r,
   output logic          empty_n_r,
   output logic [1:0]    level
);

   localparam int unsigned DEPTH = depth(aw);
   localparam int unsigned CW    = aw + 1;

   logic [aw-1:0] wp_q, wp_d;
   logic [aw-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic sclr_c;
   logic wr_en_c;
   logic rd_en_c;
   logic full_d, empty_d, full_n_d, empty_n_d;

   // Qualified operations: blocked by the flags and by reset/clear.
   always_comb begin
      sclr_c  = rst | clr;
      wr_en_c = we & ~full  & ~sclr_c;
      rd_en_c = re & ~empty & ~sclr_c;
   end

   // Next-state pointers and occupancy.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (wr_en_c) begin
         wp_d = wp_q + aw'(1);
      end
      if (rd_en_c) begin
         rp_d = rp_q + aw'(1);
      end
      if (wr_en_c && !rd_en_c) begin
         cnt_d = cnt_q + CW'(1);
      end else if (rd_en_c && !wr_en_c) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Flags decoded from the current count.
   always_comb begin
      full    = (cnt_q == CW'(DEPTH));
      empty   = (cnt_q == '0);
      full_n  = (cnt_q >= CW'(DEPTH - n));
      empty_n = (cnt_q <  CW'(n));
      level   = cnt_q[aw] ? LVL_Q3 : cnt_q[aw-1:aw-2];
   end

   // Same decode on the next count feeds the registered flag copies.
   always_comb begin
      full_d    = (cnt_d == CW'(DEPTH));
      empty_d   = (cnt_d == '0);
      full_n_d  = (cnt_d >= CW'(DEPTH - n));
      empty_n_d = (cnt_d <  CW'(n));
   end

   always_ff @(posedge clk) begin
      if (sclr_c) begin
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
         full_n_r  <= 1'b0;
         empty_n_r <= 1'b1;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         cnt_q     <= cnt_d;
         full_r    <= full_d;
         empty_r   <= empty_d;
         full_n_r  <= full_n_d;
         empty_n_r <= empty_n_d;
      end
   end

   fifo_sc_ram #(
      .dw (dw),
      .aw (aw)
   ) u_ram (
      .clk     (clk),
      .rst_i   (sclr_c),
      .we_i    (wr_en_c),
      .waddr_i (wp_q),
      .wdata_i (din),
      .re_i    (rd_en_c),
      .raddr_i (rp_q),
      .rdata_o (dout)
   );

endmodule

// File: tb/tb_generic_fifo_sc.sv
// Randomized bench for generic_fifo_sc against a queue-based reference model.
module tb_generic_fifo_sc;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 8;
   localparam int unsigned N     = 9;
   localparam int unsigned DEPTH = 256;

   logic          clk;
   logic          rst;
   logic          clr;
   logic [DW-1:0] din;
   logic          we;
   logic          re;
   logic [DW-1:0] dout;
   logic          full, empty, full_r, empty_r;
   logic          full_n, empty_n, full_n_r, empty_n_r;
   logic [1:0]    level;

   int unsigned errors = 0;
   int unsigned checks = 0;

   generic_fifo_sc #(.dw(DW), .aw(AW), .n(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .din       (din),
      .we        (we),
      .re        (re),
      .dout      (dout),
      .full      (full),
      .empty     (empty),
      .full_r    (full_r),
      .empty_r   (empty_r),
      .full_n    (full_n),
      .empty_n   (empty_n),
      .full_n_r  (full_n_r),
      .empty_n_r (empty_n_r),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: contents as a queue, read data as a held byte.
   logic [DW-1:0] model_q [$];
   logic [DW-1:0] m_dout;
   bit            chk_en = 1'b0;

   always @(posedge clk) begin
      bit do_r;
      bit do_w;
      if (rst || clr) begin
         model_q.delete();
         m_dout = '0;
         chk_en = 1'b1;
      end else begin
         do_r = re && (model_q.size() > 0);
         do_w = we && (model_q.size() < DEPTH);
         if (do_r) m_dout = model_q.pop_front();
         if (do_w) model_q.push_back(din);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      int c;
      int lv;
      if (chk_en) begin
         c  = model_q.size();
         lv = (c >= 192) ? 3 : (c >= 128) ? 2 : (c >= 64) ? 1 : 0;
         chk("dout",      int'(dout),      int'(m_dout));
         chk("full",      int'(full),      int'(c == DEPTH));
         chk("empty",     int'(empty),     int'(c == 0));
         chk("full_r",    int'(full_r),    int'(c == DEPTH));
         chk("empty_r",   int'(empty_r),   int'(c == 0));
         chk("full_n",    int'(full_n),    int'(c >= DEPTH - N));
         chk("empty_n",   int'(empty_n),   int'(c < N));
         chk("full_n_r",  int'(full_n_r),  int'(c >= DEPTH - N));
         chk("empty_n_r", int'(empty_n_r), int'(c < N));
         chk("level",     int'(level),     lv);
      end
   end

   task automatic op(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      we  = w;
      re  = r;
      din = d;
      clr = c;
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) op(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] vals [$];
      logic [DW-1:0] d;
      rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;
      @(negedge clk);

      // Reset held for 10 cycles.
      for (int i = 0; i < 10; i++) @(negedge clk);
      rst = 1'b0;
      chk("rst_empty",   int'(empty),   1);
      chk("rst_empty_r", int'(empty_r), 1);
      chk("rst_full",    int'(full),    0);
      chk("rst_empty_n", int'(empty_n), 1);
      chk("rst_full_n",  int'(full_n),  0);
      chk("rst_level",   int'(level),   0);
      chk("rst_dout",    int'(dout),    0);

      // Single write/read pairs.
      for (int i = 0; i < 5; i++) begin
         op(1'b1, 1'b0, 8'hA5, 1'b0);
         chk("single_not_empty", int'(empty), 0);
         op(1'b0, 1'b1, 8'h00, 1'b0);
         chk("single_dout",  int'(dout),  8'hA5);
         chk("single_empty", int'(empty), 1);
      end

      // Write bursts followed by equal read bursts, random idle gaps.
      for (int b = 2; b <= 4; b++) begin
         vals.delete();
         for (int i = 0; i < b; i++) begin
            d = 8'($urandom);
            vals.push_back(d);
            op(1'b1, 1'b0, d, 1'b0);
            idle(int'($urandom_range(0, 4)));
         end
         for (int i = 0; i < b; i++) begin
            op(1'b0, 1'b1, 8'h00, 1'b0);
            chk("burst_dout", int'(dout), int'(vals[i]));
            idle(int'($urandom_range(0, 4)));
         end
         chk("burst_empty", int'(empty), 1);
      end

      // Fill completely, probing the threshold boundaries.
      for (int i = 1; i <= DEPTH; i++) begin
         op(1'b1, 1'b0, 8'($urandom), 1'b0);
         if (i == 8)   chk("empty_n_at8",   int'(empty_n), 1);
         if (i == 9)   chk("empty_n_at9",   int'(empty_n), 0);
         if (i == 246) chk("full_n_at246",  int'(full_n),  0);
         if (i == 247) chk("full_n_at247",  int'(full_n),  1);
         if (i == 255) chk("full_at255",    int'(full),    0);
      end
      chk("fill_full",   int'(full),   1);
      chk("fill_full_r", int'(full_r), 1);
      chk("fill_level",  int'(level),  3);
      op(1'b1, 1'b0, 8'h3C, 1'b0);
      chk("overflow_full", int'(full), 1);
      for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_empty", int'(empty), 1);

      // Simultaneous read/write at cnt=5, then at cnt=0.
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(i + 16), 1'b0);
      for (int i = 0; i < 6; i++) op(1'b1, 1'b1, 8'($urandom), 1'b0);
      chk("rw_at5_level", int'(level), 0);
      for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rw_drain_empty", int'(empty), 1);
      d = dout;
      op(1'b1, 1'b1, 8'h77, 1'b0);
      chk("rw_at0_empty", int'(empty), 0);
      chk("rw_at0_dout_hold", int'(dout), int'(d));
      op(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rw_at0_dout", int'(dout), 8'h77);

      // Clear at cnt=100 together with a write.
      for (int i = 0; i < 100; i++) op(1'b1, 1'b0, 8'($urandom), 1'b0);
      op(1'b1, 1'b0, 8'hEE, 1'b1);
      chk("clr_empty", int'(empty), 1);
      chk("clr_level", int'(level), 0);
      chk("clr_dout",  int'(dout),  0);
      op(1'b1, 1'b0, 8'h5A, 1'b0);
      op(1'b0, 1'b1, 8'h00, 1'b0);
      chk("clr_next_dout", int'(dout), 8'h5A);

      // Random traffic with drifting write/read bias and rare clears.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = ((i / 500) % 2 == 0) ? 70 : 30;
         op(logic'($urandom_range(0, 99) < wp),
            logic'($urandom_range(0, 99) < 100 - wp),
            8'($urandom),
            logic'($urandom_range(0, 999) < 3));
      end
      clr = 1'b0; we = 1'b0; re = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/generic_fifo_sc.md
Name: generic_fifo_sc

Overview:
Single-clock synchronous FIFO of width dw and depth 2^aw, with registered read data, clear, exact and programmable-threshold full/empty flags, and a 2-bit fill-level indicator. It is the single-clock FIFO for buffering byte/word streams between producer and consumer logic in the same clock domain. The caller gates we with !full and re with !empty; the block also protects itself against overflow and underflow.

Parameters:
dw, 8, data width in bits
aw, 8, address width; depth = 2^aw entries (256 by default)
n, 9, threshold for the full_n/empty_n flags; legal range 1 to 2^aw-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
clr  in  1  synchronous clear, active-high; same effect as rst
din  in  dw  write data
we  in  1  write enable
re  in  1  read enable
dout  out  dw  read data (registered)
full  out  1  cnt == 2^aw
empty  out  1  cnt == 0
full_r  out  1  registered copy of full
empty_r  out  1  registered copy of empty
full_n  out  1  cnt >= 2^aw - n, i.e. n or fewer free slots
empty_n  out  1  cnt < n
full_n_r  out  1  registered copy of full_n
empty_n_r  out  1  registered copy of empty_n
level  out  2  coarse fill level

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- State:
  - write pointer wp and read pointer rp, aw bits each, wrap modulo 2^aw;
  - occupancy cnt, aw+1 bits, range 0 to 2^aw;
  - storage array, not reset.
- Reset/clear, at the rising edge with rst or clr high:
  - wp=rp=cnt=0, dout=0;
  - empty=empty_r=1, full=full_r=0;
  - empty_n=empty_n_r=1, full_n=full_n_r=0, level=0;
  - rst/clr override any we/re in the same cycle; the in-flight operation is discarded.
- Write: we=1 and full=0 at an edge:
  - mem[wp]<=din, wp<=wp+1.
  - we while full is ignored; no state change.
- Read: re=1 and empty=0 at an edge:
  - dout<=mem[rp], rp<=rp+1; data is visible just after that same edge (one-cycle registered read).
  - re while empty is ignored and dout holds.
  - dout holds its last value whenever no read occurs.
- Simultaneous we and re when neither flag blocks: both occur and cnt is unchanged.
  - When empty: only the write occurs; no read-through.
  - When full: only the read occurs; the write is dropped.
- Count update: cnt+1 on write only, cnt-1 on read only.
- Decoding: full, empty, full_n, empty_n and level are decoded combinationally from registered cnt.
- Registered copies: the *_r outputs are flip-flops loaded from the next-state cnt decode. They therefore equal their unregistered counterparts every cycle but drive glitch-free from flops.
- level = {cnt[aw], cnt[aw]} OR cnt[aw-1:aw-2]:
  - 0 means below 1/4 full;
  - 1 means at least 1/4;
  - 2 means at least 1/2;
  - 3 means at least 3/4 or full.
- Wrap-around: pointers roll from 2^aw-1 to 0 with data order preserved. Strict FIFO order always holds.

Decomposition:
- Package fifo_pkg: level encoding constants LVL_Q0..LVL_Q3, plus a depth function 2^aw.
- One sub-module, fifo_sc_ram: dw x 2^aw dual-port RAM with one synchronous write port and one synchronous read port with registered output and read enable. It drives dout directly.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset: pulse rst for 10 cycles -> empty=empty_r=1, full=0, empty_n=1, full_n=0, level=0, dout=0.
- Single write/read, repeated 5 times: write 0xA5, read on the next cycle -> dout=0xA5 one edge after re; empty returns to 1; cnt stays 0 afterwards.
- Bursts of 2, 3 and 4 writes, each followed by an equal read burst, with 0-4 idle cycles between operations -> dout order matches write order and no extra or missing reads occur.
- Fill with 256 writes -> full=full_r=1 and level=3.
  - full_n goes to 1 at cnt=247; empty_n goes to 0 at cnt=9.
  - A 257th write is ignored; draining then returns the original 256 values in order.
- Simultaneous we/re at cnt=5 -> cnt stays 5, data order preserved. At cnt=0 -> only the write occurs and cnt=1.
- clr asserted at cnt=100 together with we -> cnt=0, empty=1, level=0. The next write/read pair returns the new data.
